id_ex_forward_stage: RTL and testbench
======================================

Name: id_ex_forward_stage

Overview:
- ID/EX pipeline register plus EX-stage forwarding unit, directly upstream of the ALU.
- Captures decoded operands and control from ID each clock.
- Drives the ALU's ctl/in1/in2 with the hazard-resolved values: EX/MEM and MEM/WB bypass, immediate select.
- Supports stall (hold) and flush (bubble) from the hazard unit.

Parameters:
- SIZE, 9, MSB index of the data path; data width is SIZE+1 (10 bits), matching the ALU.
- RADDR, 4, MSB index of register addresses (5-bit addresses).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID slot holds a real instruction
- id_ctl  in  3  ALU control code for the instruction
- id_rs_addr / id_rt_addr  in  RADDR+1  source register numbers
- id_rs_data / id_rt_data  in  SIZE+1  register-file read data
- id_imm  in  SIZE+1  extended immediate
- id_use_imm  in  1  1 selects the immediate as ALU in2
- id_rd_addr  in  RADDR+1  destination register
- id_reg_write  in  1  instruction writes rd
- stall  in  1  hold this stage
- flush  in  1  replace the captured instruction with a bubble
- exmem_reg_write, exmem_rd_addr, exmem_result  in  1 / RADDR+1 / SIZE+1  EX/MEM producer
- memwb_reg_write, memwb_rd_addr, memwb_result  in  1 / RADDR+1 / SIZE+1  MEM/WB producer
- ctl  out  3  to ALU ctl
- in1 / in2  out  SIZE+1  to ALU operands
- ex_valid, ex_rd_addr, ex_reg_write  out  1 / RADDR+1 / 1  to EX/MEM register
- fwd_a / fwd_b  out  2  forwarding select: 00 = register, 10 = EX/MEM, 01 = MEM/WB

Behaviour:
- Reset (posedge clk with reset=1):
  - All internal registers cleared, so ex_valid=0, ex_reg_write=0, ctl=000, ex_rd_addr=0.
  - in1=in2=0, fwd_a=fwd_b=00.
  - Reset has priority over flush and stall, including when asserted mid-stall.
- Per-edge priority: reset > flush > stall > capture.
- Flush:
  - Clears the valid, reg_write and ctl registers and zeroes the operand registers.
  - Takes effect even with stall=1.
- Capture (stall=0):
  - All id_* values are registered; one cycle of latency from ID inputs to ALU outputs.
  - Write-through at capture: if memwb_reg_write=1, memwb_rd_addr != 0 and memwb_rd_addr equals id_rs_addr (or id_rt_addr), the memwb_result is registered instead of the register-file data.
- Forwarding (combinational from the registered state and the current exmem/memwb inputs; active only when ex_valid=1):
  - A = EX/MEM if exmem_reg_write=1, exmem_rd_addr != 0 and exmem_rd_addr equals the registered rs.
  - Else A = MEM/WB under the same conditions using the memwb_* inputs.
  - Else A = the registered rs data.
  - Both producers matching: EX/MEM wins (newest).
  - Register 0 is never forwarded.
  - B is resolved identically using rt.
- Operand select:
  - in1 = forwarded A.
  - in2 = registered imm if use_imm=1, else forwarded B.
  - fwd_b still reports the rt resolution when use_imm=1.
- Stall (stall=1, flush=0):
  - Control, addresses and imm are held.
  - The rs/rt data registers reload with the current forwarded A/B values, so a producer that retires during the stall is not lost.
  - A newer matching producer on the next cycle still overrides.
- Bubble (ex_valid=0): ctl=000, in1=in2=0, fwd=00, ex_reg_write=0.
- Arithmetic: none; widths pass through unchanged, with no truncation or sign handling in this block.

Test Plan:
- Reset held 2 cycles during streaming -> ex_valid=0, ctl=000, in1=in2=0 on the first edge with reset; capture resumes on the first edge after release.
- Capture ctl=001, rs=r3 data 512, rt=r4 data 256, no producers -> one cycle later ctl=001, in1=512, in2=256, fwd_a=fwd_b=00.
- Same instruction with exmem writing r3=768 and memwb writing r3=128 -> in1=768, fwd_a=10; drop exmem_reg_write -> in1=128, fwd_a=01; producer rd=r0 -> no forward.
- id_use_imm=1 with imm=511, rt forwarded from EX/MEM -> in2=511, fwd_b=10.
- Stall 3 cycles while memwb r4=513 is present only in the first cycle -> in2 stays 513 for all three cycles and after release.
- Flush asserted together with stall -> next cycle ex_valid=0, ctl=000, in1=in2=0; the next non-stalled capture proceeds normally.

Source files
------------

// File: rtl/id_ex_forward_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_forward_stage_if
// Description : Bundle of ID-side, hazard-unit, producer and ALU-side signals
//               around the ID/EX stage. The stage uses the slave modport; the
//               surrounding pipeline (or a testbench) uses the master modport.
// Revision    : 1.0  initial release
// ============================================================================
interface id_ex_forward_stage_if #(
  parameter int SIZE  = 9,
  parameter int RADDR = 4
);
  // ID stage
  logic             id_valid;
  logic [2:0]       id_ctl;
  logic [RADDR:0]   id_rs_addr;
  logic [RADDR:0]   id_rt_addr;
  logic [SIZE:0]    id_rs_data;
  logic [SIZE:0]    id_rt_data;
  logic [SIZE:0]    id_imm;
  logic             id_use_imm;
  logic [RADDR:0]   id_rd_addr;
  logic             id_reg_write;
  // hazard unit
  logic             stall;
  logic             flush;
  // producers further down the pipe
  logic             exmem_reg_write;
  logic [RADDR:0]   exmem_rd_addr;
  logic [SIZE:0]    exmem_result;
  logic             memwb_reg_write;
  logic [RADDR:0]   memwb_rd_addr;
  logic [SIZE:0]    memwb_result;
  // towards the ALU and EX/MEM register
  logic [2:0]       ctl;
  logic [SIZE:0]    in1;
  logic [SIZE:0]    in2;
  logic             ex_valid;
  logic [RADDR:0]   ex_rd_addr;
  logic             ex_reg_write;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  modport master (
    output id_valid, id_ctl, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
           id_imm, id_use_imm, id_rd_addr, id_reg_write, stall, flush,
           exmem_reg_write, exmem_rd_addr, exmem_result,
           memwb_reg_write, memwb_rd_addr, memwb_result,
    input  ctl, in1, in2, ex_valid, ex_rd_addr, ex_reg_write, fwd_a, fwd_b
  );

  modport slave (
    input  id_valid, id_ctl, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
           id_imm, id_use_imm, id_rd_addr, id_reg_write, stall, flush,
           exmem_reg_write, exmem_rd_addr, exmem_result,
           memwb_reg_write, memwb_rd_addr, memwb_result,
    output ctl, in1, in2, ex_valid, ex_rd_addr, ex_reg_write, fwd_a, fwd_b
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_forward_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_forward_stage
// Description : ID/EX pipeline register with EX-stage operand forwarding.
//               Registers the decoded instruction, resolves rs/rt against the
//               EX/MEM and MEM/WB producers and drives the ALU operands.
// Revision    : 1.0  initial release
// ============================================================================
module id_ex_forward_stage #(
  parameter int SIZE  = 9,
  parameter int RADDR = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  id_ex_forward_stage_if.slave  ex_bus
);

  logic             valid_q,     valid_d;
  logic [2:0]       ctl_q,       ctl_d;
  logic [RADDR:0]   rs_addr_q,   rs_addr_d;
  logic [RADDR:0]   rt_addr_q,   rt_addr_d;
  logic [SIZE:0]    rs_data_q,   rs_data_d;
  logic [SIZE:0]    rt_data_q,   rt_data_d;
  logic [SIZE:0]    imm_q,       imm_d;
  logic             use_imm_q,   use_imm_d;
  logic [RADDR:0]   rd_addr_q,   rd_addr_d;
  logic             reg_write_q, reg_write_d;

  logic             ex_hit_a, mw_hit_a, ex_hit_b, mw_hit_b;
  logic             wt_rs, wt_rt;
  logic [SIZE:0]    a_val, b_val;
  logic [1:0]       fwd_a, fwd_b;

  // Producer matches against the registered sources; r0 is hard-wired zero
  // and a bubble never consumes anything, so neither may match.
  assign ex_hit_a = valid_q && ex_bus.exmem_reg_write &&
                    (ex_bus.exmem_rd_addr != '0) && (ex_bus.exmem_rd_addr == rs_addr_q);
  assign mw_hit_a = valid_q && ex_bus.memwb_reg_write &&
                    (ex_bus.memwb_rd_addr != '0) && (ex_bus.memwb_rd_addr == rs_addr_q);
  assign ex_hit_b = valid_q && ex_bus.exmem_reg_write &&
                    (ex_bus.exmem_rd_addr != '0) && (ex_bus.exmem_rd_addr == rt_addr_q);
  assign mw_hit_b = valid_q && ex_bus.memwb_reg_write &&
                    (ex_bus.memwb_rd_addr != '0) && (ex_bus.memwb_rd_addr == rt_addr_q);

  // The register file is written by MEM/WB in the same cycle ID reads it, so
  // a retiring producer is written straight into the captured operand.
  assign wt_rs = ex_bus.memwb_reg_write && (ex_bus.memwb_rd_addr != '0) &&
                 (ex_bus.memwb_rd_addr == ex_bus.id_rs_addr);
  assign wt_rt = ex_bus.memwb_reg_write && (ex_bus.memwb_rd_addr != '0) &&
                 (ex_bus.memwb_rd_addr == ex_bus.id_rt_addr);

  // Operand resolution: EX/MEM is the newest producer and wins over MEM/WB.
  always_comb begin
    fwd_a = 2'b00;
    a_val = rs_data_q;
    if (ex_hit_a) begin
      fwd_a = 2'b10;
      a_val = ex_bus.exmem_result;
    end else if (mw_hit_a) begin
      fwd_a = 2'b01;
      a_val = ex_bus.memwb_result;
    end
    fwd_b = 2'b00;
    b_val = rt_data_q;
    if (ex_hit_b) begin
      fwd_b = 2'b10;
      b_val = ex_bus.exmem_result;
    end else if (mw_hit_b) begin
      fwd_b = 2'b01;
      b_val = ex_bus.memwb_result;
    end
  end

  // Next-state selection: flush beats stall beats capture.
  always_comb begin
    valid_d     = valid_q;
    ctl_d       = ctl_q;
    rs_addr_d   = rs_addr_q;
    rt_addr_d   = rt_addr_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_d       = imm_q;
    use_imm_d   = use_imm_q;
    rd_addr_d   = rd_addr_q;
    reg_write_d = reg_write_q;
    if (ex_bus.flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      ctl_d       = '0;
      rs_data_d   = '0;
      rt_data_d   = '0;
      imm_d       = '0;
    end else if (ex_bus.stall) begin
      // Keep the resolved operands so a producer retiring mid-stall survives.
      rs_data_d = a_val;
      rt_data_d = b_val;
    end else begin
      valid_d     = ex_bus.id_valid;
      ctl_d       = ex_bus.id_ctl;
      rs_addr_d   = ex_bus.id_rs_addr;
      rt_addr_d   = ex_bus.id_rt_addr;
      rs_data_d   = wt_rs ? ex_bus.memwb_result : ex_bus.id_rs_data;
      rt_data_d   = wt_rt ? ex_bus.memwb_result : ex_bus.id_rt_data;
      imm_d       = ex_bus.id_imm;
      use_imm_d   = ex_bus.id_use_imm;
      rd_addr_d   = ex_bus.id_rd_addr;
      reg_write_d = ex_bus.id_reg_write;
    end
  end

  // Pipeline register; reset overrides everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      ctl_q       <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      rd_addr_q   <= '0;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      ctl_q       <= ctl_d;
      rs_addr_q   <= rs_addr_d;
      rt_addr_q   <= rt_addr_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      use_imm_q   <= use_imm_d;
      rd_addr_q   <= rd_addr_d;
      reg_write_q <= reg_write_d;
    end
  end

  // A bubble presents an all-zero instruction to the ALU.
  assign ex_bus.ex_valid     = valid_q;
  assign ex_bus.ex_reg_write = valid_q & reg_write_q;
  assign ex_bus.ex_rd_addr   = rd_addr_q;
  assign ex_bus.ctl          = valid_q ? ctl_q : 3'b000;
  assign ex_bus.in1          = valid_q ? a_val : '0;
  assign ex_bus.in2          = !valid_q ? '0 : (use_imm_q ? imm_q : b_val);
  assign ex_bus.fwd_a        = fwd_a;
  assign ex_bus.fwd_b        = fwd_b;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_forward_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_forward_stage
// Description : Self-checking bench: directed scenarios with fixed expected
//               values, then randomized traffic against a behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_id_ex_forward_stage;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  id_ex_forward_stage_if #(.SIZE(9), .RADDR(4)) bus ();

  id_ex_forward_stage #(.SIZE(9), .RADDR(4)) dut (
    .clk    (clk),
    .reset  (rst),
    .ex_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the instruction currently held in EX
  logic       m_valid;
  logic [2:0] m_ctl;
  logic [4:0] m_rs, m_rt, m_rd;
  logic [9:0] m_rsd, m_rtd, m_imm;
  logic       m_use, m_rw;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Value a source register holds as seen from EX, given the live producers.
  function automatic logic [9:0] fwd_val(input logic [4:0] addr, input logic [9:0] regv);
    if (m_valid && bus.exmem_reg_write && bus.exmem_rd_addr != 0 && bus.exmem_rd_addr == addr)
      return bus.exmem_result;
    if (m_valid && bus.memwb_reg_write && bus.memwb_rd_addr != 0 && bus.memwb_rd_addr == addr)
      return bus.memwb_result;
    return regv;
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] addr);
    if (m_valid && bus.exmem_reg_write && bus.exmem_rd_addr != 0 && bus.exmem_rd_addr == addr)
      return 2'b10;
    if (m_valid && bus.memwb_reg_write && bus.memwb_rd_addr != 0 && bus.memwb_rd_addr == addr)
      return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [9:0] rf_read(input logic [4:0] addr, input logic [9:0] rfv);
    if (bus.memwb_reg_write && bus.memwb_rd_addr != 0 && bus.memwb_rd_addr == addr)
      return bus.memwb_result;
    return rfv;
  endfunction

  // Model update on every edge: reset > flush > stall > capture
  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0; m_ctl <= '0; m_rs <= '0; m_rt <= '0; m_rd <= '0;
      m_rsd <= '0; m_rtd <= '0; m_imm <= '0; m_use <= 1'b0; m_rw <= 1'b0;
    end else if (bus.flush) begin
      m_valid <= 1'b0; m_rw <= 1'b0; m_ctl <= '0;
      m_rsd <= '0; m_rtd <= '0; m_imm <= '0;
    end else if (bus.stall) begin
      m_rsd <= fwd_val(m_rs, m_rsd);
      m_rtd <= fwd_val(m_rt, m_rtd);
    end else begin
      m_valid <= bus.id_valid;   m_ctl <= bus.id_ctl;
      m_rs    <= bus.id_rs_addr; m_rt  <= bus.id_rt_addr;
      m_rsd   <= rf_read(bus.id_rs_addr, bus.id_rs_data);
      m_rtd   <= rf_read(bus.id_rt_addr, bus.id_rt_data);
      m_imm   <= bus.id_imm;     m_use <= bus.id_use_imm;
      m_rd    <= bus.id_rd_addr; m_rw  <= bus.id_reg_write;
    end
  end

  task automatic check_model();
    if (!m_valid) begin
      check("rnd_valid", {31'd0, bus.ex_valid}, 32'd0);
      check("rnd_ctl", {29'd0, bus.ctl}, 32'd0);
      check("rnd_in1", {22'd0, bus.in1}, 32'd0);
      check("rnd_in2", {22'd0, bus.in2}, 32'd0);
      check("rnd_fwd", {28'd0, bus.fwd_a, bus.fwd_b}, 32'd0);
      check("rnd_rw", {31'd0, bus.ex_reg_write}, 32'd0);
    end else begin
      check("rnd_valid", {31'd0, bus.ex_valid}, 32'd1);
      check("rnd_ctl", {29'd0, bus.ctl}, {29'd0, m_ctl});
      check("rnd_in1", {22'd0, bus.in1}, {22'd0, fwd_val(m_rs, m_rsd)});
      check("rnd_in2", {22'd0, bus.in2}, {22'd0, m_use ? m_imm : fwd_val(m_rt, m_rtd)});
      check("rnd_fwd_a", {30'd0, bus.fwd_a}, {30'd0, fwd_sel(m_rs)});
      check("rnd_fwd_b", {30'd0, bus.fwd_b}, {30'd0, fwd_sel(m_rt)});
      check("rnd_rw", {31'd0, bus.ex_reg_write}, {31'd0, m_rw});
      check("rnd_rd", {27'd0, bus.ex_rd_addr}, {27'd0, m_rd});
    end
  endtask

  task automatic set_id(input logic v, input logic [2:0] c, input logic [4:0] rs,
                        input logic [9:0] rsd, input logic [4:0] rt, input logic [9:0] rtd,
                        input logic [9:0] imm, input logic use_imm, input logic [4:0] rd,
                        input logic rw);
    bus.id_valid = v;     bus.id_ctl = c;
    bus.id_rs_addr = rs;  bus.id_rs_data = rsd;
    bus.id_rt_addr = rt;  bus.id_rt_data = rtd;
    bus.id_imm = imm;     bus.id_use_imm = use_imm;
    bus.id_rd_addr = rd;  bus.id_reg_write = rw;
  endtask

  task automatic set_prod(input logic ew, input logic [4:0] erd, input logic [9:0] eres,
                          input logic mw, input logic [4:0] mrd, input logic [9:0] mres);
    bus.exmem_reg_write = ew; bus.exmem_rd_addr = erd; bus.exmem_result = eres;
    bus.memwb_reg_write = mw; bus.memwb_rd_addr = mrd; bus.memwb_result = mres;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_valid"}, {31'd0, bus.ex_valid}, 32'd0);
    check({tag, "_ctl"}, {29'd0, bus.ctl}, 32'd0);
    check({tag, "_in1"}, {22'd0, bus.in1}, 32'd0);
    check({tag, "_in2"}, {22'd0, bus.in2}, 32'd0);
    check({tag, "_rw"}, {31'd0, bus.ex_reg_write}, 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_prod(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    check("rst_fwd", {28'd0, bus.fwd_a, bus.fwd_b}, 32'd0);
    check("rst_rd", {27'd0, bus.ex_rd_addr}, 32'd0);
    chk_zero("rst");

    // Stream an instruction, then reset for two edges in the middle of it
    rst = 1'b0;
    set_id(1, 3'b001, 5'd3, 10'd512, 5'd4, 10'd256, 10'd0, 0, 5'd7, 1);
    @(negedge clk);
    check("cap_ctl", {29'd0, bus.ctl}, 32'd1);
    check("cap_in1", {22'd0, bus.in1}, 32'd512);
    check("cap_in2", {22'd0, bus.in2}, 32'd256);
    check("cap_fwd", {28'd0, bus.fwd_a, bus.fwd_b}, 32'd0);
    check("cap_rd", {27'd0, bus.ex_rd_addr}, 32'd7);
    check("cap_rw", {31'd0, bus.ex_reg_write}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst1");
    @(negedge clk);
    chk_zero("rst2");
    rst = 1'b0;
    @(negedge clk);
    check("resume_ctl", {29'd0, bus.ctl}, 32'd1);
    check("resume_in1", {22'd0, bus.in1}, 32'd512);
    check("resume_in2", {22'd0, bus.in2}, 32'd256);

    // Forwarding priority and the r0 exclusion
    set_prod(1, 5'd3, 10'd768, 1, 5'd3, 10'd128);
    #1;
    check("exmem_in1", {22'd0, bus.in1}, 32'd768);
    check("exmem_fwd_a", {30'd0, bus.fwd_a}, 32'd2);
    bus.exmem_reg_write = 1'b0;
    #1;
    check("memwb_in1", {22'd0, bus.in1}, 32'd128);
    check("memwb_fwd_a", {30'd0, bus.fwd_a}, 32'd1);
    set_prod(1, 5'd0, 10'd768, 1, 5'd0, 10'd128);
    #1;
    check("r0_in1", {22'd0, bus.in1}, 32'd512);
    check("r0_fwd_a", {30'd0, bus.fwd_a}, 32'd0);

    // Immediate select while rt is still forwarded
    set_id(1, 3'b001, 5'd3, 10'd512, 5'd4, 10'd256, 10'd511, 1, 5'd7, 1);
    set_prod(1, 5'd4, 10'd300, 0, 5'd0, 10'd0);
    @(negedge clk);
    check("imm_in2", {22'd0, bus.in2}, 32'd511);
    check("imm_fwd_b", {30'd0, bus.fwd_b}, 32'd2);
    check("imm_in1", {22'd0, bus.in1}, 32'd512);

    // Stall with a producer that retires after the first stalled cycle
    set_id(1, 3'b001, 5'd3, 10'd512, 5'd4, 10'd256, 10'd0, 0, 5'd7, 1);
    set_prod(0, 5'd0, 10'd0, 0, 5'd0, 10'd0);
    @(negedge clk);
    bus.stall = 1'b1;
    set_prod(0, 5'd0, 10'd0, 1, 5'd4, 10'd513);
    #1;
    check("stall0_in2", {22'd0, bus.in2}, 32'd513);
    check("stall0_fwd_b", {30'd0, bus.fwd_b}, 32'd1);
    @(negedge clk);
    set_prod(0, 5'd0, 10'd0, 0, 5'd0, 10'd0);
    set_id(1, 3'b101, 5'd9, 10'd1, 5'd4, 10'd2, 10'd3, 0, 5'd8, 0);
    #1;
    check("stall1_in2", {22'd0, bus.in2}, 32'd513);
    check("stall1_ctl", {29'd0, bus.ctl}, 32'd1);
    @(negedge clk);
    check("stall2_in2", {22'd0, bus.in2}, 32'd513);
    check("stall2_rd", {27'd0, bus.ex_rd_addr}, 32'd7);
    bus.stall = 1'b0;
    set_id(1, 3'b001, 5'd3, 10'd512, 5'd4, 10'd513, 10'd0, 0, 5'd7, 1);
    @(negedge clk);
    check("release_in2", {22'd0, bus.in2}, 32'd513);
    check("release_ctl", {29'd0, bus.ctl}, 32'd1);

    // Flush wins over stall, then normal capture resumes
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    chk_zero("flush");
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    set_id(1, 3'b011, 5'd5, 10'd100, 5'd6, 10'd200, 10'd0, 0, 5'd2, 1);
    @(negedge clk);
    check("post_flush_ctl", {29'd0, bus.ctl}, 32'd3);
    check("post_flush_in1", {22'd0, bus.in1}, 32'd100);
    check("post_flush_in2", {22'd0, bus.in2}, 32'd200);

    // Write-through from a retiring MEM/WB producer at capture time
    set_prod(0, 5'd0, 10'd0, 1, 5'd5, 10'd77);
    @(negedge clk);
    set_prod(0, 5'd0, 10'd0, 0, 5'd0, 10'd0);
    #1;
    check("wt_in1", {22'd0, bus.in1}, 32'd77);
    check("wt_fwd_a", {30'd0, bus.fwd_a}, 32'd0);

    // Reset asserted while stalled
    bus.stall = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst_stall");
    rst = 1'b0;
    bus.stall = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      check_model();
      rst       = ($urandom_range(0, 49) == 0);
      bus.flush = ($urandom_range(0, 14) == 0);
      bus.stall = ($urandom_range(0, 3) == 0);
      set_id(1'($urandom_range(0, 5) != 0), 3'($urandom), 5'($urandom_range(0, 7)),
             10'($urandom), 5'($urandom_range(0, 7)), 10'($urandom), 10'($urandom),
             1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom));
      set_prod(1'($urandom), 5'($urandom_range(0, 7)), 10'($urandom),
               1'($urandom), 5'($urandom_range(0, 7)), 10'($urandom));
      #1;
      check_model();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
